// File: rtl/pipe_scroller_pkg.sv
// Shared Flappy game definitions: screen/pipe geometry, LFSR seed and state encodings.
// Used by the pipe scroller and the obstacle checker.
package pipe_scroller_pkg;

  localparam int unsigned GAME_SCREEN_W = 640;
  localparam int unsigned GAME_PIPE_W   = 80;
  localparam int unsigned GAME_GAP_H    = 100;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // One-hot so the state bits drive Q_Idle/Q_Scroll/Q_Frozen directly
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SCROLL = 3'b010,
    ST_FROZEN = 3'b100
  } state_e;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
  } pipe_t;

endpackage

// File: rtl/pipe_scroller_if.sv
// Game-side bus of the pipe scroller: control inputs, pipe geometry and score outputs.
interface pipe_scroller_if;
  logic       Frame_Tick;
  logic       Start;
  logic       Lose;
  logic       Ack;
  logic [9:0] Bird_X;
  logic [9:0] X_Edge;
  logic [9:0] Y_Edge;
  logic [9:0] Pipe0_X;
  logic [9:0] Pipe0_Y;
  logic [9:0] Pipe1_X;
  logic [9:0] Pipe1_Y;
  logic [7:0] Score;
  logic       Pass;
  logic       Q_Idle;
  logic       Q_Scroll;
  logic       Q_Frozen;

  modport master (
    output Frame_Tick, Start, Lose, Ack, Bird_X,
    input  X_Edge, Y_Edge, Pipe0_X, Pipe0_Y, Pipe1_X, Pipe1_Y,
    input  Score, Pass, Q_Idle, Q_Scroll, Q_Frozen
  );

  modport slave (
    input  Frame_Tick, Start, Lose, Ack, Bird_X,
    output X_Edge, Y_Edge, Pipe0_X, Pipe0_Y, Pipe1_X, Pipe1_Y,
    output Score, Pass, Q_Idle, Q_Scroll, Q_Frozen
  );
endinterface

// File: rtl/pipe_scroller_lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4, loaded with seed_i on reset.
module lfsr8 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [7:0] seed_i,
  output logic [7:0] q_o
);
  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en_i) begin
      q_d = {q_q[6:0], q_q[7] ^ q_q[5] ^ q_q[4] ^ q_q[3]};
      // Escape the lock-up state should a zero seed ever be supplied
      if (q_q == '0) q_d = 8'h01;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) q_q <= seed_i;
    else         q_q <= q_d;
  end

  assign q_o = q_q;
endmodule

// File: rtl/pipe_scroller.sv
// Two-pipe generator/scroller: moves pipes left per frame, respawns them with random gap
// heights, selects the pipe in scope for the checker and counts passes.
module pipe_scroller
  import pipe_scroller_pkg::*;
#(
  parameter int unsigned SCREEN_W = GAME_SCREEN_W,
  parameter int unsigned SPACING  = 320,
  parameter int unsigned PIPE_W   = GAME_PIPE_W,
  parameter int unsigned SPEED    = 2,
  parameter int unsigned Y_MIN    = 40,
  parameter int unsigned Y_INIT0  = 120,
  parameter int unsigned Y_INIT1  = 200
) (
  input  logic           Clk,
  input  logic           reset,
  pipe_scroller_if.slave bus
);
  localparam logic [9:0]  X_INIT0     = 10'(SCREEN_W);
  localparam logic [9:0]  X_INIT1     = 10'(SCREEN_W + SPACING);
  localparam logic [9:0]  RESPAWN_ADD = 10'(2 * SPACING - SPEED);
  localparam logic [9:0]  SPD         = 10'(SPEED);
  localparam logic [9:0]  YMIN        = 10'(Y_MIN);
  localparam logic [10:0] PW          = 11'(PIPE_W);
  localparam pipe_t       INIT0       = '{x: X_INIT0, y: 10'(Y_INIT0)};
  localparam pipe_t       INIT1       = '{x: X_INIT1, y: 10'(Y_INIT1)};

  typedef struct packed {
    pipe_t p;
    logic  passed;
  } step_t;

  function automatic step_t pipe_step(input pipe_t cur, input logic [7:0] rnd,
                                      input logic [10:0] bx);
    step_t       s;
    logic [10:0] re_old;
    logic [10:0] re_new;
    s.p = cur;
    if (cur.x >= SPD) begin
      s.p.x = cur.x - SPD;
    end else begin
      s.p.x = cur.x + RESPAWN_ADD;
      s.p.y = YMIN + {2'b00, rnd};
    end
    re_old   = {1'b0, cur.x} + PW;
    re_new   = {1'b0, s.p.x} + PW;
    s.passed = (re_old >= bx) && (re_new < bx);
    return s;
  endfunction

  state_e      state_q, state_d;
  pipe_t       p0_q, p0_d, p1_q, p1_d;
  logic [7:0]  score_q, score_d;
  logic        pass_q, pass_d;
  logic [9:0]  xe_q, xe_d, ye_q, ye_d;
  logic [7:0]  lfsr;
  logic [7:0]  rnd1;
  logic [10:0] bx;
  logic [10:0] re0, re1;
  logic [1:0]  n_pass;
  logic [8:0]  score_sum;
  step_t       step0, step1;

  lfsr8 u_lfsr (
    .clk_i  (Clk),
    .rst_ni (reset),
    .en_i   (1'b1),
    .seed_i (LFSR_SEED),
    .q_o    (lfsr)
  );

  assign bx = {1'b0, bus.Bird_X};

  // A simultaneous respawn gives pipe 1 the nibble-swapped value so both gaps differ
  assign rnd1  = (p0_q.x < SPD && p1_q.x < SPD) ? {lfsr[3:0], lfsr[7:4]} : lfsr;
  assign step0 = pipe_step(p0_q, lfsr, bx);
  assign step1 = pipe_step(p1_q, rnd1, bx);

  assign n_pass    = {1'b0, step0.passed} + {1'b0, step1.passed};
  assign score_sum = {1'b0, score_q} + {7'b0, n_pass};

  always_comb begin
    state_d = state_q;
    p0_d    = p0_q;
    p1_d    = p1_q;
    score_d = score_q;
    pass_d  = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (bus.Start) state_d = ST_SCROLL;
      ST_SCROLL: begin
        if (bus.Lose) begin
          state_d = ST_FROZEN;
        end else if (bus.Frame_Tick) begin
          p0_d    = step0.p;
          p1_d    = step1.p;
          score_d = score_sum[8] ? 8'hFF : score_sum[7:0];
          pass_d  = step0.passed | step1.passed;
        end
      end
      ST_FROZEN: if (bus.Ack) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      p0_d    = INIT0;
      p1_d    = INIT1;
      score_d = '0;
    end
  end

  // In-scope pipe: nearest pipe whose right edge has not yet cleared the bird
  assign re0 = {1'b0, p0_q.x} + PW;
  assign re1 = {1'b0, p1_q.x} + PW;

  always_comb begin
    xe_d = p0_q.x;
    ye_d = p0_q.y;
    if ((re1 >= bx) && (!(re0 >= bx) || (p1_q.x < p0_q.x))) begin
      xe_d = p1_q.x;
      ye_d = p1_q.y;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      p0_q    <= INIT0;
      p1_q    <= INIT1;
      score_q <= '0;
      pass_q  <= 1'b0;
      xe_q    <= X_INIT0;
      ye_q    <= 10'(Y_INIT0);
    end else begin
      state_q <= state_d;
      p0_q    <= p0_d;
      p1_q    <= p1_d;
      score_q <= score_d;
      pass_q  <= pass_d;
      xe_q    <= xe_d;
      ye_q    <= ye_d;
    end
  end

  assign bus.X_Edge   = xe_q;
  assign bus.Y_Edge   = ye_q;
  assign bus.Pipe0_X  = p0_q.x;
  assign bus.Pipe0_Y  = p0_q.y;
  assign bus.Pipe1_X  = p1_q.x;
  assign bus.Pipe1_Y  = p1_q.y;
  assign bus.Score    = score_q;
  assign bus.Pass     = pass_q;
  assign bus.Q_Idle   = (state_q == ST_IDLE);
  assign bus.Q_Scroll = (state_q == ST_SCROLL);
  assign bus.Q_Frozen = (state_q == ST_FROZEN);
endmodule

// File: tb/tb_pipe_scroller.sv
// Self-checking bench for pipe_scroller: vector table, directed corner sequences and
// randomized traffic against a behavioural game model.
module tb_pipe_scroller;
  localparam int SCR = 640, SPC = 320, PW = 80, SPD = 2, YMIN = 40, YI0 = 120, YI1 = 200;
  localparam int M_IDLE = 0, M_SCROLL = 1, M_FROZEN = 2;

  logic Clk;
  logic reset;
  pipe_scroller_if bus ();

  pipe_scroller #(
    .SCREEN_W (SCR),
    .SPACING  (SPC),
    .PIPE_W   (PW),
    .SPEED    (SPD),
    .Y_MIN    (YMIN),
    .Y_INIT0  (YI0),
    .Y_INIT1  (YI1)
  ) dut (
    .Clk   (Clk),
    .reset (reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int         m_state, m_score, m_pass, m_xe, m_ye;
  int         m_x[2];
  int         m_y[2];
  logic [7:0] m_lfsr;
  int         n_checks, n_fail;

  typedef struct {
    logic rst_n, start, tick, lose, ack;
    int   st, p0x, p1x, score;
  } vec_t;
  vec_t tbl[15];

  task automatic summary_and_finish();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      if (n_fail >= 50) summary_and_finish();
    end
  endtask

  // Game rules applied once per rising edge, using the inputs held across that edge
  task automatic model_step();
    int bx, n, old_re;
    bit both;
    bx = int'(bus.Bird_X);
    if (!reset) begin
      m_state = M_IDLE;
      m_x[0] = SCR; m_x[1] = SCR + SPC; m_y[0] = YI0; m_y[1] = YI1;
      m_score = 0; m_pass = 0; m_xe = SCR; m_ye = YI0; m_lfsr = 8'hA5;
      return;
    end
    if ((m_x[1] + PW >= bx) && (!(m_x[0] + PW >= bx) || m_x[1] < m_x[0])) begin
      m_xe = m_x[1]; m_ye = m_y[1];
    end else begin
      m_xe = m_x[0]; m_ye = m_y[0];
    end
    m_pass = 0;
    case (m_state)
      M_IDLE:   if (bus.Start) m_state = M_SCROLL;
      M_SCROLL: begin
        if (bus.Lose) m_state = M_FROZEN;
        else if (bus.Frame_Tick) begin
          both = (m_x[0] < SPD) && (m_x[1] < SPD);
          n = 0;
          for (int i = 0; i < 2; i++) begin
            old_re = m_x[i] + PW;
            if (m_x[i] >= SPD) m_x[i] = m_x[i] - SPD;
            else begin
              m_x[i] = m_x[i] + 2 * SPC - SPD;
              m_y[i] = YMIN + ((both && i == 1) ? (((int'(m_lfsr) << 4) | (int'(m_lfsr) >> 4)) & 255)
                                                : int'(m_lfsr));
            end
            if (old_re >= bx && m_x[i] + PW < bx) n++;
          end
          m_score = (m_score + n > 255) ? 255 : m_score + n;
          m_pass  = (n > 0) ? 1 : 0;
        end
      end
      default:  if (bus.Ack) m_state = M_IDLE;
    endcase
    if (m_state == M_IDLE) begin
      m_x[0] = SCR; m_x[1] = SCR + SPC; m_y[0] = YI0; m_y[1] = YI1; m_score = 0;
    end
    m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
  endtask

  task automatic compare_all();
    check("state", int'({bus.Q_Frozen, bus.Q_Scroll, bus.Q_Idle}), 1 << m_state);
    check("Pipe0_X", int'(bus.Pipe0_X), m_x[0]);
    check("Pipe0_Y", int'(bus.Pipe0_Y), m_y[0]);
    check("Pipe1_X", int'(bus.Pipe1_X), m_x[1]);
    check("Pipe1_Y", int'(bus.Pipe1_Y), m_y[1]);
    check("Score", int'(bus.Score), m_score);
    check("Pass", int'(bus.Pass), m_pass);
    check("X_Edge", int'(bus.X_Edge), m_xe);
    check("Y_Edge", int'(bus.Y_Edge), m_ye);
  endtask

  task automatic apply(input logic r, input logic s, input logic t, input logic l, input logic a);
    @(negedge Clk);
    reset = r; bus.Start = s; bus.Frame_Tick = t; bus.Lose = l; bus.Ack = a;
    @(posedge Clk);
    model_step();
    #1;
    compare_all();
  endtask

  initial begin
    #3ms;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    summary_and_finish();
  end

  initial begin
    int n, prev, exp_y;
    bit sat_seen;
    n_checks = 0; n_fail = 0;
    reset = 1'b0; bus.Frame_Tick = 1'b0; bus.Start = 1'b0; bus.Lose = 1'b0; bus.Ack = 1'b0;
    bus.Bird_X = 10'd100;

    //              rst  start tick  lose  ack   state     p0x  p1x  score
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, M_IDLE,   640, 960, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, M_SCROLL, 640, 960, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_SCROLL, 638, 958, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_SCROLL, 636, 956, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, M_SCROLL, 636, 956, 0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, M_SCROLL, 634, 954, 0};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, M_SCROLL, 632, 952, 0};
    tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, M_FROZEN, 632, 952, 0};
    tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_FROZEN, 632, 952, 0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, M_IDLE,   640, 960, 0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, M_IDLE,   640, 960, 0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, M_SCROLL, 640, 960, 0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_SCROLL, 638, 958, 0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, M_IDLE,   640, 960, 0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, M_IDLE,   640, 960, 0};

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].rst_n, tbl[i].start, tbl[i].tick, tbl[i].lose, tbl[i].ack);
      check($sformatf("tbl%0d_state", i), int'({bus.Q_Frozen, bus.Q_Scroll, bus.Q_Idle}),
            1 << tbl[i].st);
      check($sformatf("tbl%0d_p0x", i), int'(bus.Pipe0_X), tbl[i].p0x);
      check($sformatf("tbl%0d_p1x", i), int'(bus.Pipe1_X), tbl[i].p1x);
      check($sformatf("tbl%0d_score", i), int'(bus.Score), tbl[i].score);
    end

    // Ten frames after Start; X_Edge follows one cycle later
    apply(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_xedge", int'(bus.X_Edge), 640);
    check("rst_yedge", int'(bus.Y_Edge), 120);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (10) apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("t10_p0x", int'(bus.Pipe0_X), 620);
    check("t10_p1x", int'(bus.Pipe1_X), 940);
    check("t10_score", int'(bus.Score), 0);
    apply(1'b1, 1'b0, 0, 1'b0, 1'b0);
    check("t10_xedge", int'(bus.X_Edge), 620);

    // Right edge 100 -> 98 against Bird_X=100 is a pass
    n = 0;
    while (m_x[0] != 20 && n < 400) begin apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); n++; end
    check("pass_pre_x", int'(bus.Pipe0_X), 20);
    check("pass_pre_score", int'(bus.Score), 0);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pass_score", int'(bus.Score), 1);
    check("pass_pulse", int'(bus.Pass), 1);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pass_pulse_end", int'(bus.Pass), 0);
    check("pass_score_hold", int'(bus.Score), 1);

    // Respawn from x=0
    n = 0;
    while (m_x[0] != 0 && n < 20) begin apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); n++; end
    check("resp_pre_x", int'(bus.Pipe0_X), 0);
    exp_y = YMIN + int'(m_lfsr);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("resp_x", int'(bus.Pipe0_X), 638);
    check("resp_y", int'(bus.Pipe0_Y), exp_y);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("resp_xedge", int'(bus.X_Edge), 318);
    check("resp_yedge", int'(bus.Y_Edge), 200);

    // Lose beats Frame_Tick; Ack+Start in FROZEN goes only to IDLE
    apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    check("lose_p0x", int'(bus.Pipe0_X), 638);
    check("lose_p1x", int'(bus.Pipe1_X), 318);
    check("lose_state", int'({bus.Q_Frozen, bus.Q_Scroll, bus.Q_Idle}), 4);
    check("lose_score", int'(bus.Score), 1);
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    check("ack_state", int'({bus.Q_Frozen, bus.Q_Scroll, bus.Q_Idle}), 1);
    check("ack_score", int'(bus.Score), 0);
    check("ack_p0x", int'(bus.Pipe0_X), 640);

    // Reset mid-scroll at x=300
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0;
    while (m_x[0] != 300 && n < 400) begin apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); n++; end
    check("mid_x", int'(bus.Pipe0_X), 300);
    apply(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_rst_idle", int'(bus.Q_Idle), 1);
    check("mid_rst_p0x", int'(bus.Pipe0_X), 640);
    check("mid_rst_xedge", int'(bus.X_Edge), 640);

    // Score saturation: keep scrolling until a pass lands while already at 255
    apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n = 0; sat_seen = 0;
    while (!sat_seen && n < 45000) begin
      prev = m_score;
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      n++;
      if (prev == 255 && m_pass == 1) sat_seen = 1;
    end
    check("sat_reached", int'(sat_seen), 1);
    check("sat_score", int'(bus.Score), 255);
    check("sat_pass", int'(bus.Pass), 1);

    // Randomized traffic
    for (int c = 0; c < 15000; c++) begin
      if (c % 1000 == 0) bus.Bird_X = 10'($urandom_range(0, 200));
      apply(($urandom_range(0, 255) == 0) ? 1'b0 : 1'b1,
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
            1'($urandom_range(0, 1)),
            ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
    end

    summary_and_finish();
  end
endmodule
